// File: rtl/stack_ctrl.sv
// Hardware operand stack sequencer: turns push/pop/top strobes into timed accesses
// on a single-port, synchronous-read stack RAM and tracks pointer, status and faults.
module stack_ctrl #(
   parameter int DW = 8,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          top,
   input  logic [DW-1:0] din,
   input  logic          clr_err,
   output logic          ready,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full,
   output logic          ovf,
   output logic          unf,
   output logic          cmd_err,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2,
      S_CAP  = 2'd3
   } state_t;

   localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        r_state;
   state_t        w_next;
   logic [AW:0]   r_count;
   logic [DW-1:0] r_dout;
   logic          r_dout_valid;
   logic          r_ovf;
   logic          r_unf;
   logic          r_cmd_err;
   logic [AW-1:0] r_ram_addr;
   logic          r_ram_we;
   logic [DW-1:0] r_ram_wdata;
   logic          r_is_pop;

   logic          w_idle;
   logic          w_multi;
   logic          w_rd_req;
   logic          w_full;
   logic          w_empty;
   logic          w_acc_push;
   logic          w_acc_rd;
   logic          w_ovf_ev;
   logic          w_unf_ev;
   logic          w_cmd_ev;

   assign w_idle   = (r_state == S_IDLE);
   assign w_multi  = (push & pop) | (push & top) | (pop & top);
   assign w_rd_req = pop | top;
   assign w_full   = (r_count == DEPTH);
   assign w_empty  = (r_count == {(AW+1){1'b0}});

   // Request decode; strobes only matter while idle.
   always_comb begin
      w_acc_push = 1'b0;
      w_acc_rd   = 1'b0;
      w_ovf_ev   = 1'b0;
      w_unf_ev   = 1'b0;
      w_cmd_ev   = 1'b0;
      if (w_idle) begin
         if (w_multi) begin
            w_cmd_ev = 1'b1;
         end else if (push) begin
            w_acc_push = ~w_full;
            w_ovf_ev   = w_full;
         end else if (w_rd_req) begin
            w_acc_rd = ~w_empty;
            w_unf_ev = w_empty;
         end else begin
            w_acc_push = 1'b0;
         end
      end else begin
         w_acc_push = 1'b0;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (w_acc_push) begin
               w_next = S_WR;
            end else if (w_acc_rd) begin
               w_next = S_RD;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WR:    w_next = S_IDLE;
         S_RD:    w_next = S_CAP;
         S_CAP:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Stack pointer and RAM port registers; address is set up one cycle ahead of use.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count     <= {(AW+1){1'b0}};
         r_ram_addr  <= {AW{1'b0}};
         r_ram_we    <= 1'b0;
         r_ram_wdata <= {DW{1'b0}};
         r_is_pop    <= 1'b0;
      end else begin
         r_ram_we <= w_acc_push;
         if (w_acc_push) begin
            r_ram_addr  <= r_count[AW-1:0];
            r_ram_wdata <= din;
         end else if (w_acc_rd) begin
            r_ram_addr <= r_count[AW-1:0] - ADDR_ONE;
            r_is_pop   <= pop;
         end
         if (r_state == S_WR) begin
            r_count <= r_count + CNT_ONE;
         end else if ((r_state == S_CAP) && r_is_pop) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Read capture and the one-cycle valid pulse that follows it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout       <= {DW{1'b0}};
         r_dout_valid <= 1'b0;
      end else begin
         r_dout_valid <= (r_state == S_CAP);
         if (r_state == S_CAP) begin
            r_dout <= ram_rdata;
         end
      end
   end

   // Sticky fault flags; a new fault in the same cycle as clr_err wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_cmd_err <= 1'b0;
      end else begin
         r_ovf     <= (r_ovf & ~clr_err) | w_ovf_ev;
         r_unf     <= (r_unf & ~clr_err) | w_unf_ev;
         r_cmd_err <= (r_cmd_err & ~clr_err) | w_cmd_ev;
      end
   end

   assign ready      = w_idle;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign count      = r_count;
   assign empty      = w_empty;
   assign full       = w_full;
   assign ovf        = r_ovf;
   assign unf        = r_unf;
   assign cmd_err    = r_cmd_err;
   assign ram_addr   = r_ram_addr;
   assign ram_we     = r_ram_we;
   assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (4-entry stack) with a behavioural RAM and a read-data scoreboard.
module tb_stack_ctrl;

   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk;
   logic          rst;
   logic          push;
   logic          pop;
   logic          top;
   logic [DW-1:0] din;
   logic          clr_err;
   logic          ready;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          ovf;
   logic          unf;
   logic          cmd_err;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;
   int            m_count = 0;

   stack_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .top(top), .din(din),
      .clr_err(clr_err), .ready(ready), .dout(dout), .dout_valid(dout_valid),
      .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf),
      .cmd_err(cmd_err), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous-read stack RAM.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every dout_valid pulse must match the oldest expected read.
   always @(negedge clk) begin
      if (rst && dout_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_valid", 32'd1, 32'd0);
         end else begin
            chk("sb_dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [DW-1:0] d);
      chk("push_ready_N", {31'd0, ready}, 32'd1);
      push = 1'b1;
      din  = d;
      step();
      push = 1'b0;
      chk("push_we_N1", {31'd0, ram_we}, 32'd1);
      chk("push_addr_N1", {30'd0, ram_addr}, m_count);
      chk("push_wdata_N1", {24'd0, ram_wdata}, {24'd0, d});
      chk("push_ready_N1", {31'd0, ready}, 32'd0);
      step();
      m_count++;
      chk("push_ready_N2", {31'd0, ready}, 32'd1);
      chk("push_we_N2", {31'd0, ram_we}, 32'd0);
      chk("push_count", {29'd0, count}, m_count);
   endtask

   task automatic do_read(input bit is_pop, input logic [DW-1:0] expv, input bit jam_push);
      chk("rd_ready_N", {31'd0, ready}, 32'd1);
      pop = is_pop;
      top = ~is_pop;
      exp_q.push_back(expv);
      step();
      pop  = 1'b0;
      top  = 1'b0;
      push = jam_push;
      din  = 8'h77;
      chk("rd_ready_N1", {31'd0, ready}, 32'd0);
      chk("rd_addr_N1", {30'd0, ram_addr}, m_count - 1);
      chk("rd_we_N1", {31'd0, ram_we}, 32'd0);
      step();
      chk("rd_ready_N2", {31'd0, ready}, 32'd0);
      chk("rd_we_N2", {31'd0, ram_we}, 32'd0);
      step();
      push = 1'b0;
      if (is_pop) m_count--;
      chk("rd_valid_N3", {31'd0, dout_valid}, 32'd1);
      chk("rd_dout_N3", {24'd0, dout}, {24'd0, expv});
      chk("rd_ready_N3", {31'd0, ready}, 32'd1);
      chk("rd_count_N3", {29'd0, count}, m_count);
      step();
      chk("rd_valid_N4", {31'd0, dout_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; push = 1'b0; pop = 1'b0; top = 1'b0; din = 8'h00; clr_err = 1'b0;
      step();
      step();
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_flags", {29'd0, ovf, unf, cmd_err}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      rst = 1'b1;
      step();
      chk("rst_ready", {31'd0, ready}, 32'd1);

      // Reset asserted while in WR
      push = 1'b1; din = 8'hEE;
      step();
      push = 1'b0;
      chk("mid_we_before", {31'd0, ram_we}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_we_async", {31'd0, ram_we}, 32'd0);
      chk("mid_addr_async", {30'd0, ram_addr}, 32'd0);
      chk("mid_wdata_async", {24'd0, ram_wdata}, 32'd0);
      step();
      rst = 1'b1;
      step();
      chk("mid_count", {29'd0, count}, 32'd0);
      chk("mid_ready", {31'd0, ready}, 32'd1);

      // Push three, top, pop three
      do_push(8'h11);
      do_push(8'h22);
      do_push(8'h33);
      do_read(1'b0, 8'h33, 1'b0);
      do_read(1'b1, 8'h33, 1'b0);
      do_read(1'b1, 8'h22, 1'b0);
      do_read(1'b1, 8'h11, 1'b0);
      chk("drain_empty", {31'd0, empty}, 32'd1);

      // Underflow
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk("unf_flag", {31'd0, unf}, 32'd1);
      chk("unf_ready", {31'd0, ready}, 32'd1);
      chk("unf_dout", {24'd0, dout}, 32'h11);
      step();
      chk("unf_no_valid", {31'd0, dout_valid}, 32'd0);
      chk("unf_count", {29'd0, count}, 32'd0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("unf_clr", {31'd0, unf}, 32'd0);

      // Fill and overflow
      do_push(8'hA0);
      do_push(8'hA1);
      do_push(8'hA2);
      do_push(8'hA3);
      chk("fill_full", {31'd0, full}, 32'd1);
      push = 1'b1; din = 8'hA4;
      step();
      push = 1'b0;
      chk("ovf_flag", {31'd0, ovf}, 32'd1);
      chk("ovf_we", {31'd0, ram_we}, 32'd0);
      chk("ovf_ready", {31'd0, ready}, 32'd1);
      step();
      chk("ovf_we_later", {31'd0, ram_we}, 32'd0);
      chk("ovf_count", {29'd0, count}, 32'd4);
      chk("ovf_full", {31'd0, full}, 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("ovf_clr", {31'd0, ovf}, 32'd0);

      // Fault in the same cycle as clr_err wins
      push = 1'b1; clr_err = 1'b1;
      step();
      push = 1'b0; clr_err = 1'b0;
      chk("ovf_vs_clr", {31'd0, ovf}, 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("ovf_clr2", {31'd0, ovf}, 32'd0);

      // Multiple strobes
      push = 1'b1; pop = 1'b1;
      step();
      push = 1'b0; pop = 1'b0;
      chk("cmd_flag", {31'd0, cmd_err}, 32'd1);
      chk("cmd_we", {31'd0, ram_we}, 32'd0);
      chk("cmd_ready", {31'd0, ready}, 32'd1);
      step();
      chk("cmd_count", {29'd0, count}, 32'd4);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("cmd_clr", {31'd0, cmd_err}, 32'd0);

      // Push while busy is ignored, then back-to-back push/pop
      do_read(1'b1, 8'hA3, 1'b1);
      chk("jam_count", {29'd0, count}, 32'd3);
      do_push(8'h5C);
      do_read(1'b1, 8'h5C, 1'b0);
      do_read(1'b1, 8'hA2, 1'b0);
      do_read(1'b1, 8'hA1, 1'b0);
      do_read(1'b1, 8'hA0, 1'b0);
      chk("end_empty", {31'd0, empty}, 32'd1);
      chk("end_flags", {29'd0, ovf, unf, cmd_err}, 32'd0);
      step();
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
